// File: rtl/udp_tx_arb_pkg.sv
// Shared types and helpers for the UDP transmit arbiter.
// Holds the FSM state encoding, bus widths and the round-robin successor function.
package udp_tx_arb_pkg;

  localparam int LEN_W  = 11;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Successor inside the round-robin ring 1..nreq-1; index 0 never takes part.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nreq);
    if (nreq < 2 || idx + 1 >= nreq) return 1;
    return idx + 1;
  endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// Rotating priority encoder over requesters 1..NREQ-1.
// The search starts at ptr and wraps within the ring. Bit 0 of req is ignored.
module rr_pick
  import udp_tx_arb_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic             valid
);

  int unsigned cand;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    cand  = int'(ptr);
    for (int k = 0; k < NREQ - 1; k++) begin
      for (int unsigned i = 1; i < NREQ; i++) begin
        if (!valid && i == cand && req[i]) begin
          gnt[i] = 1'b1;
          valid  = 1'b1;
        end
      end
      cand = rr_next(cand, NREQ);
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Shares the MAC UDP transmit port between NREQ packers: index 0 has absolute priority,
// the rest rotate. The grant is held for the latched length, followed by an idle gap.
module udp_tx_arbiter
  import udp_tx_arb_pkg::*;
#(
  parameter int          NREQ       = 3,
  parameter int          GAP_CYCLES = 4,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_request,
  output logic [NREQ-1:0]         req_enable,
  input  logic [DATA_W*NREQ-1:0]  req_data,
  input  logic [LEN_W*NREQ-1:0]   req_length,
  output logic                    udp_tx_request,
  input  logic                    udp_tx_enable,
  output logic [DATA_W-1:0]       udp_tx_data,
  output logic [LEN_W-1:0]        udp_tx_length,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic                    timeout_pulse
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t             state;
  logic [LEN_W-1:0]   byte_cnt;
  logic [15:0]        to_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [PTR_W-1:0]   rr_ptr;

  logic [NREQ-1:0]    rr_gnt;
  logic               rr_valid;
  logic [NREQ-1:0]    sel;
  logic [LEN_W-1:0]   sel_len;
  logic [DATA_W-1:0]  g_data;
  int unsigned        g_idx;
  logic               g_req;
  logic               active;
  logic               gap_done;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req   (req_request),
    .ptr   (rr_ptr),
    .gnt   (rr_gnt),
    .valid (rr_valid)
  );

  always_comb begin
    sel = '0;
    if (req_request[0]) sel[0] = 1'b1;
    else if (rr_valid)  sel = rr_gnt;
  end

  always_comb begin
    sel_len = '0;
    g_data  = '0;
    g_idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel[i])   sel_len = req_length[i*LEN_W +: LEN_W];
      if (grant[i]) begin
        g_data = req_data[i*DATA_W +: DATA_W];
        g_idx  = i;
      end
    end
  end

  assign g_req          = |(req_request & grant);
  assign active         = (state == GRANT) || (state == XFER);
  assign gap_done       = (gap_cnt >= GAP_LAST);
  assign udp_tx_request = (state == GRANT) && g_req;
  assign req_enable     = active ? (grant & {NREQ{udp_tx_enable}}) : '0;
  assign udp_tx_data    = active ? g_data : '0;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      grant         <= '0;
      udp_tx_length <= '0;
      timeout_pulse <= 1'b0;
      rr_ptr        <= PTR_W'(1);
      byte_cnt      <= '0;
      to_cnt        <= '0;
      gap_cnt       <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (|sel) begin
            grant         <= sel;
            udp_tx_length <= sel_len;
            to_cnt        <= '0;
            state         <= GRANT;
          end
        end
        GRANT: begin
          // Acceptance wins over a same-cycle drop; timeout wins over withdrawal.
          if (udp_tx_enable) begin
            byte_cnt <= udp_tx_length;
            gap_cnt  <= '0;
            if (udp_tx_length == '0) state <= GAP;
            else                     state <= XFER;
          end else if (to_cnt == TIMEOUT - 16'd1) begin
            timeout_pulse <= 1'b1;
            gap_cnt       <= '0;
            state         <= GAP;
          end else if (!g_req) begin
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        XFER: begin
          if (byte_cnt <= LEN_W'(1)) begin
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            byte_cnt <= byte_cnt - LEN_W'(1);
          end
        end
        GAP: begin
          if (gap_done) begin
            grant <= '0;
            if (g_idx != 0) rr_ptr <= PTR_W'(rr_next(g_idx, NREQ));
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter: directed scenarios plus randomized packets,
// checked against a transaction-level model that keeps the round-robin order as a queue.
module tb_udp_tx_arbiter;

  localparam int          NREQ = 3;
  localparam int          GAP  = 4;
  localparam logic [15:0] TMO  = 16'd100;

  logic                clk = 1'b0;
  logic                rstn;
  logic [NREQ-1:0]     req_request;
  logic [NREQ-1:0]     req_enable;
  logic [8*NREQ-1:0]   req_data;
  logic [11*NREQ-1:0]  req_length;
  logic                udp_tx_request;
  logic                udp_tx_enable;
  logic [7:0]          udp_tx_data;
  logic [10:0]         udp_tx_length;
  logic [NREQ-1:0]     grant;
  logic                busy;
  logic                timeout_pulse;

  int checks = 0;
  int errors = 0;

  logic [7:0] dat [NREQ];
  int         lens[NREQ];
  int         order[$];

  udp_tx_arbiter #(
    .NREQ       (NREQ),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .req_request    (req_request),
    .req_enable     (req_enable),
    .req_data       (req_data),
    .req_length     (req_length),
    .udp_tx_request (udp_tx_request),
    .udp_tx_enable  (udp_tx_enable),
    .udp_tx_data    (udp_tx_data),
    .udp_tx_length  (udp_tx_length),
    .grant          (grant),
    .busy           (busy),
    .timeout_pulse  (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    req_data   = {dat[2], dat[1], dat[0]};
    req_length = {11'(lens[2]), 11'(lens[1]), 11'(lens[0])};
  endtask

  // Source 0 always wins; otherwise the first requester in the rotation queue.
  function automatic int pick(input logic [2:0] m);
    if (m[0]) return 0;
    foreach (order[j]) if (((int'(m) >> order[j]) & 1) != 0) return order[j];
    return -1;
  endfunction

  // A served ring member and everything ahead of it move to the back of the queue.
  function automatic void served(input int i);
    int x;
    if (i == 0) return;
    for (int s = 0; s < NREQ; s++) begin
      x = order.pop_front();
      order.push_back(x);
      if (x == i) break;
    end
  endfunction

  // en_delay < 0: MAC never enables (timeout). reset_at >= 0: reset at that XFER byte.
  task automatic packet(input logic [2:0] mask, input int en_delay, input bit withdraw,
                        input int reset_at);
    int         w, n, m, k, pulses;
    logic [2:0] wm;
    logic [10:0] exp_len;
    w       = pick(mask);
    wm      = 3'(1 << w);
    exp_len = 11'(lens[w]);
    req_request = mask;
    step();
    chk("grant", grant, wm);
    chk("len_latch", udp_tx_length, exp_len);
    chk("busy_grant", busy, 1);
    chk("tx_request", udp_tx_request, 1);
    chk("grant_data", udp_tx_data, dat[w]);
    req_request = wm;
    if (en_delay < 0) begin
      k = 0;
      while (!timeout_pulse && k < int'(TMO) + 10) begin
        chk("tmo_wait_enable", req_enable, 0);
        k++;
        step();
      end
      chk("timeout_cycles", k, TMO);
      req_request = '0;
    end else begin
      repeat (en_delay) begin
        step();
        chk("wait_enable", req_enable, 0);
        chk("hold_grant", grant, wm);
      end
      if (withdraw) begin
        req_request = '0;
        #1;
        chk("withdraw_req", udp_tx_request, 0);
        step();
      end else begin
        udp_tx_enable = 1'b1;
        #1;
        chk("enable_mirror", req_enable, wm);
        step();
        req_request = '0;
        n = 0;
        while (req_enable != '0 && n < 2100) begin
          if (n == reset_at) begin
            rstn = 1'b0;
            step();
            rstn = 1'b1;
            udp_tx_enable = 1'b0;
            chk("rst_grant", grant, 0);
            chk("rst_busy", busy, 0);
            chk("rst_txreq", udp_tx_request, 0);
            chk("rst_len", udp_tx_length, 0);
            chk("rst_enable", req_enable, 0);
            order = {1, 2};
            return;
          end
          for (int j = 0; j < NREQ; j++) begin
            dat[j]  = (j == w) ? 8'($urandom) : ((n % 2 != 0) ? 8'hAA : 8'h55);
            lens[j] = int'($urandom_range(0, 2047));
          end
          drive();
          #1;
          chk("xfer_data", udp_tx_data, dat[w]);
          chk("xfer_enable", req_enable, wm);
          chk("xfer_len", udp_tx_length, exp_len);
          chk("xfer_txreq", udp_tx_request, 0);
          n++;
          step();
        end
        chk("xfer_cycles", n, exp_len);
        udp_tx_enable = 1'b0;
      end
    end
    pulses = 0;
    m = 0;
    while (grant != '0 && m < 20) begin
      chk("gap_enable", req_enable, 0);
      chk("gap_data", udp_tx_data, 0);
      pulses += int'(timeout_pulse);
      m++;
      step();
    end
    chk("gap_cycles", m, GAP);
    chk("idle_busy", busy, 0);
    chk("timeout_count", pulses, (en_delay < 0) ? 1 : 0);
    served(w);
  endtask

  initial begin
    order = {1, 2};
    rstn = 1'b0;
    udp_tx_enable = 1'b0;
    req_request = 3'b111;
    for (int j = 0; j < NREQ; j++) begin
      dat[j]  = 8'h11 * 8'(j + 1);
      lens[j] = 0;
    end
    drive();
    repeat (3) step();
    chk("rst_grant0", grant, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_txreq0", udp_tx_request, 0);
    chk("rst_len0", udp_tx_length, 0);
    chk("rst_pulse0", timeout_pulse, 0);
    chk("rst_enable0", req_enable, 0);
    req_request = '0;
    rstn = 1'b1;
    step();
    chk("idle_after_rst", busy, 0);

    lens = '{0, 1032, 0};
    drive();
    packet(3'b010, 3, 1'b0, -1);

    lens = '{60, 20, 30};
    drive();
    packet(3'b110, 2, 1'b0, -1);
    packet(3'b111, 1, 1'b0, -1);
    packet(3'b110, 0, 1'b0, -1);
    packet(3'b110, 2, 1'b0, -1);
    packet(3'b010, 1, 1'b0, -1);

    packet(3'b100, -1, 1'b0, -1);
    packet(3'b110, 1, 1'b0, -1);

    lens = '{5, 7, 0};
    drive();
    packet(3'b100, 1, 1'b0, -1);
    packet(3'b010, 2, 1'b1, -1);

    lens = '{5, 800, 9};
    drive();
    packet(3'b010, 0, 1'b0, 500);
    lens = '{5, 12, 9};
    drive();
    packet(3'b110, 1, 1'b0, -1);

    for (int t = 0; t < 25; t++) begin
      logic [2:0] mk;
      int         r;
      mk = 3'($urandom_range(1, 7));
      for (int j = 0; j < NREQ; j++) begin
        lens[j] = int'($urandom_range(0, 40));
        dat[j]  = 8'($urandom);
      end
      drive();
      r = int'($urandom_range(0, 11));
      packet(mk, (r == 0) ? -1 : int'($urandom_range(0, 4)), r == 1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
